cxl_order_accumulator: RTL
==========================

Name: cxl_order_accumulator

Overview:
- Parametrised per-client cancelled-order accumulator for the downstream path.
- Each accepted request adds an amount to the running total held for its client, then reports the new total.
- The read-modify-write is a 2-stage pipeline over a synchronous-read RAM, with same-client forwarding, saturating arithmetic, a post-reset RAM clear sweep and an optional set (overwrite) mode.
- Sits between the cancel-order decoder and the downstream risk logic.

Parameters:
- ID_W, 5: client id width.
- NUM_CLIENTS, 1<<ID_W: number of client entries; must be ≤ 2**ID_W.
- AMT_W, 16: request amount width.
- ACC_W, 32: accumulator width; must be ≥ AMT_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_client_id  in  ID_W  client index.
- in_amount  in  AMT_W  unsigned amount.
- in_set  in  1  1 = overwrite the total with in_amount; 0 = add in_amount.
- out_valid  out  1  one-cycle pulse carrying a result.
- out_client_id  out  ID_W  client of the result.
- out_total  out  ACC_W  new total for that client.
- out_saturated  out  1  the update clamped at the maximum.
- cxl_limit  in  ACC_W  threshold; port exists only under CXL_LIMIT_EN.
- out_over_limit  out  1  total ≥ threshold; port exists only under CXL_LIMIT_EN.

Behaviour:
- Reset is asynchronous and active-low, on rst_n; the block has one clock, clk.
- While rst_n=0:
  - FSM goes to INIT and the sweep counter clears to 0.
  - Both pipeline valid flags clear; in_ready=0.
  - out_valid=0, out_client_id=0, out_total=0, out_saturated=0, out_over_limit=0.
- FSM states:
  - INIT: writes 0 to address sweep_cnt each cycle and increments it. After the cycle that writes NUM_CLIENTS-1, go to RUN. INIT lasts exactly NUM_CLIENTS cycles. in_ready=0 throughout.
  - RUN: in_ready=1 permanently; there is no output backpressure. The block does not leave RUN except through reset.
- Accept: a request is accepted at an edge where in_valid & in_ready = 1.
- Stage 1 (edge E):
  - The RAM read of in_client_id is issued.
  - id, amount and set are registered and s1_valid is set.
- Stage 2 (edge E+1):
  - Operand A = forwarded value if the hazard below applies; otherwise RAM read data.
  - Result = in_set ? amount : A + amount.
  - Result is written to the RAM at s1 id. The out_* registers load; out_valid=1 for one cycle.
  - Latency: out_valid is high during the cycle after edge E+1, i.e. 2 edges after accept.
- RAM read-during-write returns old data, so the block must forward:
  - If the request accepted at edge E+1 has the same id as the stage-2 write at E+1, its operand is the stage-2 result.
  - Back-to-back same-client requests at full rate must therefore accumulate correctly.
  - Requests for different clients never forward.
- Arithmetic:
  - Unsigned. amount is zero-extended to ACC_W.
  - The sum is computed at ACC_W+1 bits. If the carry is set, the result is 2**ACC_W-1 and out_saturated=1; otherwise out_saturated=0.
  - Set mode never saturates.
- Ids ≥ NUM_CLIENTS are accepted but do not write the RAM. out_total=0 and out_saturated=0 for these.
- Reset mid-operation: in-flight requests are dropped without an out_valid, and the RAM is re-cleared by INIT.

Optional Feature:
- Macro: CXL_LIMIT_EN.
- Defined:
  - The cxl_limit and out_over_limit ports exist.
  - out_over_limit is registered together with out_valid and equals (result ≥ cxl_limit), where cxl_limit is sampled at stage 2.
  - out_over_limit is 0 whenever out_valid=0.
- Undefined: both ports and the comparator are absent. All other behaviour is identical.

Decomposition:
- Package cxl_pkg holds:
  - the state typedef enum {INIT, RUN}.
  - default width constants (ID_W, AMT_W, ACC_W).
  - the function sat_add(acc, amt) returning {sat, sum}.
- Sub-module cxl_acc_ram: single write port and one synchronous read port, parametrised by DATA_W and ADDR_W, with read-during-write returning old data.

Test Plan:
- Reset then hold: in_ready stays 0 for exactly 32 cycles and rises on cycle 33; a query of every id returns total 0.
- Single request id=3, amt=100, then id=3, amt=50 with an idle gap: out_total=100, then 150; latency is 2 edges each.
- Back-to-back id=7 amounts 1, 2, 3, 4 on consecutive cycles: out_total=1, 3, 6, 10 (exercises forwarding). Interleaving id=7 and id=8 keeps the two totals independent.
- Saturation with ACC_W=16: set id=0 to 65530, then add 10 → out_total=65535, out_saturated=1. A following add of 0 → 65535, out_saturated=0.
- Set mode: id=5 accumulates to 500, then in_set=1 amt=20 → 20; the next add 5 → 25.
- Reset asserted while two requests are in flight: no out_valid appears for them, INIT reruns, and their ids read 0 afterwards. With CXL_LIMIT_EN and cxl_limit=100, totals 99 → over=0 and 100 → over=1.

Source files
------------

// File: rtl/cxl_pkg.sv
// Shared types and helpers for the cancelled-order accumulator.
// Holds the FSM state encoding, default widths and the saturating adder.
// sat_add works on SAT_MAX_W-bit operands; callers pass their real width (< SAT_MAX_W).
package cxl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_ID_W  = 5;
  localparam int DEF_AMT_W = 16;
  localparam int DEF_ACC_W = 32;

  // Working width of sat_add; accumulator widths up to SAT_MAX_W-1 are supported.
  localparam int SAT_MAX_W = 64;

  // Returns {sat, sum}. Both operands must already fit in 'width' bits, so the
  // only way to exceed the all-ones limit is a carry out of bit width-1.
  function automatic logic [SAT_MAX_W:0] sat_add(input logic [SAT_MAX_W-1:0] acc,
                                                 input logic [SAT_MAX_W-1:0] amt,
                                                 input int                   width);
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    logic               sat;
    sum = {1'b0, acc} + {1'b0, amt};
    lim = ((SAT_MAX_W+1)'(1) << width) - (SAT_MAX_W+1)'(1);
    sat = (sum > lim);
    return {sat, (sat ? lim[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0])};
  endfunction

endpackage

// File: rtl/cxl_acc_ram.sv
// Per-client total storage: one write port, one synchronous read port.
// Latency: read data valid the cycle after re; a same-edge write is not visible (old data).
// No backpressure; both ports accept every cycle.
// Ports: clk; we/waddr/wdat write port; re/raddr read request; rdat registered read data.
module cxl_acc_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdat,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdat
);

  logic [DATA_W-1:0] mem [1<<ADDR_W];

  // Read and write share one edge; the read samples the array before the
  // write lands, which is what gives read-during-write its old-data behaviour.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdat;
    end
    if (re) begin
      rdat <= mem[raddr];
    end
  end

endmodule

// File: rtl/cxl_order_accumulator.sv
// Per-client cancelled-order accumulator: adds (or sets) an amount into a client total, reports the new total.
// Latency: out_valid pulses 2 edges after accept (RAM read at accept edge, update/write/report at the next).
// Backpressure: in_ready=0 during the post-reset clear sweep (NUM_CLIENTS cycles), then 1 forever; no output stall.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_client_id/in_amount/in_set request;
//        out_valid/out_client_id/out_total/out_saturated result; with CXL_LIMIT_EN also cxl_limit in, out_over_limit out.
// Optional feature macro: CXL_LIMIT_EN (threshold compare on the reported total).
module cxl_order_accumulator
  import cxl_pkg::*;
#(
  parameter int ID_W        = DEF_ID_W,
  parameter int NUM_CLIENTS = 1 << ID_W,
  parameter int AMT_W       = DEF_AMT_W,
  parameter int ACC_W       = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ID_W-1:0]  in_client_id,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_set,
  output logic             out_valid,
  output logic [ID_W-1:0]  out_client_id,
  output logic [ACC_W-1:0] out_total,
  output logic             out_saturated
`ifdef CXL_LIMIT_EN
  ,
  input  logic [ACC_W-1:0] cxl_limit,
  output logic             out_over_limit
`endif
);

  // ---------------------------------------------------------------- FSM
  state_t          state, state_nxt;
  logic [ID_W-1:0] sweep_cnt, sweep_nxt;
  logic            sweep_last;

  assign sweep_last = (sweep_cnt == ID_W'(NUM_CLIENTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_cnt;
    in_ready  = 1'b0;
    case (state)
      INIT: begin
        sweep_nxt = sweep_cnt + ID_W'(1);
        if (sweep_last) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------- stage 1
  logic             accept;
  logic             s1_valid;
  logic [ID_W-1:0]  s1_id;
  logic [AMT_W-1:0] s1_amt;
  logic             s1_set;
  logic             s1_fwd;
  logic [ACC_W-1:0] s1_fwd_dat;
  logic             s1_in_range;

  // Stage-2 combinational results, declared here because stage 1 captures them for forwarding.
  logic [ACC_W-1:0] res;
  logic             res_sat;

  assign accept      = in_valid & in_ready;
  assign s1_in_range = ({1'b0, s1_id} < (ID_W+1)'(NUM_CLIENTS));

  // The RAM read issued at this edge cannot see the write stage 2 performs at
  // the same edge, so a same-client follower captures that result directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s1_amt     <= '0;
      s1_set     <= 1'b0;
      s1_fwd     <= 1'b0;
      s1_fwd_dat <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_id      <= in_client_id;
        s1_amt     <= in_amount;
        s1_set     <= in_set;
        s1_fwd     <= s1_valid && s1_in_range && (s1_id == in_client_id);
        s1_fwd_dat <= res;
      end
    end
  end

  // ---------------------------------------------------------------- RAM
  logic             ram_we;
  logic [ID_W-1:0]  ram_waddr;
  logic [ACC_W-1:0] ram_wdat;
  logic [ACC_W-1:0] ram_rdat;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_id;
    ram_wdat  = res;
    if (state == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_cnt;
      ram_wdat  = '0;
    end else if (s1_valid && s1_in_range) begin
      ram_we = 1'b1;
    end
  end

  cxl_acc_ram #(
    .DATA_W (ACC_W),
    .ADDR_W (ID_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdat  (ram_wdat),
    .re    (accept),
    .raddr (in_client_id),
    .rdat  (ram_rdat)
  );

  // ---------------------------------------------------------------- stage 2
  logic [ACC_W-1:0]   operand;
  logic [SAT_MAX_W:0] sum_w;
  logic               unused_sum;
  logic [ACC_W-1:0]   rep_total;
  logic               rep_sat;

  assign operand    = s1_fwd ? s1_fwd_dat : ram_rdat;
  assign sum_w      = sat_add(SAT_MAX_W'(operand), SAT_MAX_W'(s1_amt), ACC_W);
  assign unused_sum = ^sum_w;

  // Set mode bypasses the adder entirely, so it can never saturate.
  assign res     = s1_set ? ACC_W'(s1_amt) : sum_w[ACC_W-1:0];
  assign res_sat = ~s1_set & sum_w[SAT_MAX_W];

  // Out-of-range ids are acknowledged but report an empty, unsaturated total.
  assign rep_total = s1_in_range ? res : '0;
  assign rep_sat   = s1_in_range & res_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_client_id <= '0;
      out_total     <= '0;
      out_saturated <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_client_id <= s1_id;
        out_total     <= rep_total;
        out_saturated <= rep_sat;
      end
    end
  end

`ifdef CXL_LIMIT_EN
  // Qualified with s1_valid so the flag never lingers outside a result pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_over_limit <= 1'b0;
    end else begin
      out_over_limit <= s1_valid & (rep_total >= cxl_limit);
    end
  end
`endif

endmodule
